// File: rtl/wb_daq_sample_sram.sv
// Wishbone B3 sample SRAM for a DAQ path: single-cycle classic and
// zero-wait registered-feedback bursts, plus write-beat counter and
// watermark interrupt. Optional macro WB_DAQ_SAMPLE_SRAM_RANGE_CHECK_EN
// enables address range checking with wb_err_o termination.
// Ports:
//   wb_clk, wb_rst            clock, synchronous active-high reset
//   wb_adr_i/dat_i/sel_i      byte address, write data, lane enables
//   wb_we_i/cyc_i/stb_i       Wishbone control
//   wb_cti_i/bte_i            cycle type, burst type
//   wb_dat_o/ack_o/err_o/rty_o read data and terminations
//   count_clr, watermark      counter clear pulse, irq threshold
//   word_count, watermark_irq write beat count, level interrupt
module wb_daq_sample_sram #(
   parameter int dw = 32,
   parameter int aw = 32,
   parameter int depth_log2 = 10,
   parameter logic [aw-1:0] base_addr = 32'h0000_0000
) (
   input  logic          wb_clk,
   input  logic          wb_rst,
   input  logic [aw-1:0] wb_adr_i,
   input  logic [dw-1:0] wb_dat_i,
   input  logic [3:0]    wb_sel_i,
   input  logic          wb_we_i,
   input  logic          wb_cyc_i,
   input  logic          wb_stb_i,
   input  logic [2:0]    wb_cti_i,
   input  logic [1:0]    wb_bte_i,
   output logic [dw-1:0] wb_dat_o,
   output logic          wb_ack_o,
   output logic          wb_err_o,
   output logic          wb_rty_o,
   input  logic          count_clr,
   input  logic [15:0]   watermark,
   output logic [15:0]   word_count,
   output logic          watermark_irq
);

   localparam int DEPTH = 1 << depth_log2;
   localparam logic [depth_log2-1:0] ONE = {{(depth_log2-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {S_IDLE, S_SINGLE, S_BURST} t_state;

   t_state                r_state;
   logic                  r_ack;
   logic                  r_err;
   logic [dw-1:0]         r_dat;
   logic [depth_log2-1:0] r_badr;
   logic [15:0]           r_count;
   logic                  r_irq;
   logic [dw-1:0]         r_mem [DEPTH];

   logic [depth_log2-1:0] w_idx;
   logic [depth_log2-1:0] w_base;
   logic [depth_log2-1:0] w_inc;
   logic [depth_log2-1:0] w_next;
   logic                  w_we;
   logic                  w_bad;
   logic                  w_unused;

   assign w_idx = wb_adr_i[depth_log2+1:2];

`ifdef WB_DAQ_SAMPLE_SRAM_RANGE_CHECK_EN
   assign w_bad    = wb_adr_i[aw-1:depth_log2+2] !=
                     base_addr[aw-1:depth_log2+2];
   assign wb_err_o = r_err;
   assign w_unused = ^wb_adr_i[1:0];
`else
   assign w_bad    = 1'b0;
   assign wb_err_o = 1'b0;
   assign w_unused = ^{wb_adr_i[aw-1:depth_log2+2], wb_adr_i[1:0],
                       base_addr, r_err};
`endif

   // Predicted next word: from the request address on the first beat,
   // from the registered burst address afterwards.
   always_comb begin
      w_base = (r_state == S_BURST) ? r_badr : w_idx;
      w_inc  = w_base + ONE;
      w_next = w_inc;
      case (wb_bte_i)
         2'b01:   w_next = {w_base[depth_log2-1:2], w_inc[1:0]};
         2'b10:   w_next = {w_base[depth_log2-1:3], w_inc[2:0]};
         2'b11:   w_next = {w_base[depth_log2-1:4], w_inc[3:0]};
         default: w_next = w_inc;
      endcase
   end

   // Reset at a beat edge suppresses that beat's write.
   assign w_we = wb_cyc_i & wb_stb_i & wb_we_i & r_ack & ~wb_rst;

   always_ff @(posedge wb_clk) begin
      if (w_we) begin
         for (int b = 0; b < 4; b++) begin
            if (wb_sel_i[b]) r_mem[w_idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
         end
      end
   end

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         r_state <= S_IDLE;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_dat   <= '0;
         r_badr  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_ack <= 1'b0;
               r_err <= 1'b0;
               if (wb_cyc_i && wb_stb_i) begin
                  r_dat  <= r_mem[w_idx];
                  r_badr <= w_next;
                  if (w_bad) begin
                     r_err   <= 1'b1;
                     r_state <= S_SINGLE;
                  end else begin
                     r_ack   <= 1'b1;
                     r_state <= (wb_cti_i == 3'b010) ? S_BURST : S_SINGLE;
                  end
               end
            end
            S_SINGLE: begin
               r_ack   <= 1'b0;
               r_err   <= 1'b0;
               r_state <= S_IDLE;
            end
            S_BURST: begin
               if (!wb_cyc_i) begin
                  r_ack   <= 1'b0;
                  r_state <= S_IDLE;
               end else if (r_ack && wb_stb_i && wb_cti_i == 3'b111) begin
                  r_ack   <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_ack <= wb_stb_i;
                  // Advance only when a beat actually completes.
                  if (r_ack && wb_stb_i) begin
                     r_dat  <= r_mem[r_badr];
                     r_badr <= w_next;
                  end
               end
            end
            default: begin
               r_ack   <= 1'b0;
               r_err   <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         r_count <= '0;
         r_irq   <= 1'b0;
      end else begin
         if (count_clr) r_count <= '0;
         else if (w_we && r_count != 16'hFFFF) r_count <= r_count + 16'd1;
         r_irq <= (watermark != 16'd0) && (r_count >= watermark);
      end
   end

   assign wb_dat_o      = r_dat;
   assign wb_ack_o      = r_ack;
   assign wb_rty_o      = 1'b0;
   assign word_count    = r_count;
   assign watermark_irq = r_irq;

endmodule

// File: doc/wb_daq_sample_sram.md
WB_DAQ_SAMPLE_SRAM -- requirements
Module: wb_daq_sample_sram

Interface
REQ-001 SHALL have parameter dw, default 32: data width; only 32 is supported.
REQ-002 SHALL have parameter aw, default 32: address width.
REQ-003 SHALL have parameter depth_log2, default 10: memory depth as log2 of the word count (1024 words).
REQ-004 SHALL have parameter base_addr, default 32'h0000_0000: byte base address, aligned to 2^(depth_log2+2).
REQ-005 SHALL use one clock and a synchronous, active-high reset; these ports SHALL be listed first, as follows.
REQ-006 wb_clk  input  1  sole clock; all logic on the rising edge.
REQ-007 wb_rst  input  1  synchronous reset, active-high.
REQ-008 wb_adr_i  input  aw  byte address.
REQ-009 wb_dat_i  input  32  write data.
REQ-010 wb_sel_i  input  4  byte lane enables.
REQ-011 wb_we_i, wb_cyc_i, wb_stb_i  input  1 each  Wishbone B3 control.
REQ-012 wb_cti_i  input  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst.
REQ-013 wb_bte_i  input  2  burst type: 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16.
REQ-014 wb_dat_o  output  32  read data.
REQ-015 wb_ack_o, wb_err_o, wb_rty_o  output  1 each  termination signals.
REQ-016 count_clr  input  1  single-cycle pulse that clears word_count.
REQ-017 watermark  input  16  interrupt threshold, in words.
REQ-018 word_count  output  16  number of write beats accepted since the last clear.
REQ-019 watermark_irq  output  1  level interrupt.

Function
REQ-020 SHALL implement three states: IDLE, SINGLE and BURST.
REQ-021 In IDLE, on wb_cyc_i&wb_stb_i, SHALL raise ack on the next cycle. Next state SHALL be BURST if wb_cti_i==010, otherwise SINGLE.
REQ-022 In SINGLE, ack SHALL be high for exactly one cycle, then return to IDLE. A classic access therefore takes 2 cycles per beat.
REQ-023 In BURST, ack SHALL follow wb_stb_i combinationally-free, i.e. registered, with zero wait states. A stb-low cycle SHALL hold ack low and the burst address unchanged.
REQ-024 SHALL exit BURST to IDLE after the acked beat where wb_cti_i==111, or immediately when wb_cyc_i drops.
REQ-025 A write SHALL occur at a clock edge with wb_cyc_i&wb_stb_i&wb_we_i&wb_ack_o, at word index wb_adr_i[depth_log2+1:2]. Only the bytes enabled by wb_sel_i SHALL be written.
REQ-026 Read data for the first beat SHALL be fetched from wb_adr_i. Read data for subsequent burst beats SHALL be fetched from the predicted next address: linear +1, or wrap within a 4/8/16-word block per wb_bte_i. wb_dat_o SHALL be valid in every cycle that ack is high.
REQ-027 Linear bursts SHALL wrap from the last word to word 0.
REQ-028 wb_rty_o SHALL be constant 0.
REQ-029 word_count SHALL increment by 1 per write beat and saturate at 16'hFFFF.
REQ-030 When count_clr coincides with a write beat, the clear SHALL win and word_count SHALL be 0.
REQ-031 watermark_irq SHALL be registered and SHALL equal (watermark!=0 && word_count>=watermark), updating one cycle after word_count changes.

Reset
REQ-032 While wb_rst is high: state=IDLE, wb_ack_o=0, wb_err_o=0, wb_dat_o=0, word_count=0, watermark_irq=0.
REQ-033 Memory contents SHALL NOT be reset.
REQ-034 When reset is asserted mid-burst, no write SHALL occur at that edge, and ack SHALL be low on the next cycle.

Configuration
REQ-035 Macro WB_DAQ_SAMPLE_SRAM_RANGE_CHECK_EN defined: an access with wb_adr_i[aw-1:depth_log2+2] != base_addr[aw-1:depth_log2+2] SHALL get a one-cycle wb_err_o instead of ack. It SHALL cause no write and no count, SHALL return to IDLE, and wb_err_o and wb_ack_o SHALL never both be high.
REQ-036 Macro undefined: the upper address bits SHALL be ignored, i.e. the memory aliases across the whole address space, and wb_err_o SHALL be constant 0.

Verification
REQ-037 Classic write 32'hDEADBEEF, sel 4'hF, to 0x10, then classic read of 0x10 -> ack is 1 cycle per access, read returns 32'hDEADBEEF, word_count=1.
REQ-038 Write 32'h11223344 to 0x20 with sel 4'hF, then write 32'hAABBCCDD with sel 4'b0101 -> read returns 32'h11BB33DD.
REQ-039 8-beat linear write burst from 0x0 with data 0..7, then wrap-4 read burst starting at 0x8 -> ack high for 8 consecutive cycles; read order is words 2,3,0,1 = data 2,3,0,1.
REQ-040 watermark=4, then 4 write beats -> watermark_irq rises on the cycle after word_count reaches 4. count_clr in the same cycle as a 5th beat -> word_count=0 and irq falls.
REQ-041 wb_rst asserted on beat 3 of a 6-beat write burst -> ack=0 on the next cycle, word_count=0, words 0-1 written and word 2 unwritten.
REQ-042 With WB_DAQ_SAMPLE_SRAM_RANGE_CHECK_EN defined and base_addr=0, a write to 0x1000 -> one-cycle wb_err_o, no ack, and word 0 unchanged. With the macro undefined, the same write -> ack, and word 0 is written.
